// File: rtl/spi_track_frame_rx.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | spi_track_frame_rx : 3-wire SPI receiver for one frame of per-track words  |
// |   committed atomically, with length check, change flags and frame counter |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module spi_track_frame_rx #(
   parameter int NUM_TRACKS  = 4,
   parameter int PACKET_SIZE = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              cs,
   input  logic                              sck,
   input  logic                              sdi,
   output logic [NUM_TRACKS*PACKET_SIZE-1:0] tracks_out,
   output logic                              frame_valid,
   output logic                              frame_err,
   output logic [NUM_TRACKS-1:0]             track_upd,
   output logic [7:0]                        frame_cnt,
   output logic                              busy
);

   localparam int W     = NUM_TRACKS * PACKET_SIZE;
   localparam int CNT_W = $clog2(W + 1);
   localparam int ARM_W = $clog2(SYNC_STAGES + 2);
   localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(W);
   localparam logic [ARM_W-1:0] C_ARM_DONE = ARM_W'(SYNC_STAGES + 1);

   typedef enum logic [1:0] {
      ARM   = 2'd0,
      IDLE  = 2'd1,
      SHIFT = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [SYNC_STAGES-1:0]  cs_sync_q, cs_sync_d;
   logic [SYNC_STAGES-1:0]  sck_sync_q, sck_sync_d;
   logic [SYNC_STAGES-1:0]  sdi_sync_q, sdi_sync_d;
   logic                    cs_dly_q, sck_dly_q;
   logic [W-1:0]            shift_q, shift_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    ovf_q, ovf_d;
   logic [ARM_W-1:0]        arm_cnt_q, arm_cnt_d;
   logic [W-1:0]            tracks_q, tracks_d;
   logic                    frame_valid_q, frame_valid_d;
   logic                    frame_err_q, frame_err_d;
   logic [NUM_TRACKS-1:0]   track_upd_q, track_upd_d;
   logic [7:0]              frame_cnt_q, frame_cnt_d;
   logic [NUM_TRACKS-1:0]   word_diff;

   logic cs_s, sck_s, sdi_s;
   logic rise_sck, rise_cs, fall_cs;

   assign cs_sync_d  = {cs_sync_q[SYNC_STAGES-2:0], cs};
   assign sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], sck};
   assign sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], sdi};

   assign cs_s  = cs_sync_q[SYNC_STAGES-1];
   assign sck_s = sck_sync_q[SYNC_STAGES-1];
   assign sdi_s = sdi_sync_q[SYNC_STAGES-1];

   assign rise_sck = sck_s & ~sck_dly_q;
   assign rise_cs  = cs_s & ~cs_dly_q;
   assign fall_cs  = ~cs_s & cs_dly_q;

   generate
      for (genvar i = 0; i < NUM_TRACKS; i++) begin : g_track
         assign word_diff[i] = shift_q[(i+1)*PACKET_SIZE-1 -: PACKET_SIZE]
                            != tracks_q[(i+1)*PACKET_SIZE-1 -: PACKET_SIZE];
      end
   endgenerate

   always_comb begin
      state_d       = state_q;
      shift_d       = shift_q;
      cnt_d         = cnt_q;
      ovf_d         = ovf_q;
      arm_cnt_d     = arm_cnt_q;
      tracks_d      = tracks_q;
      frame_valid_d = 1'b0;
      frame_err_d   = 1'b0;
      track_upd_d   = '0;
      frame_cnt_d   = frame_cnt_q;
      case (state_q)
         ARM: begin
            // Synchronisers are zeroed by reset, so cs_s is not trustworthy
            // until the pipeline has refilled from the real pin.
            if (arm_cnt_q != C_ARM_DONE) begin
               arm_cnt_d = arm_cnt_q + 1'b1;
            end else if (!cs_s) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            if (rise_cs) begin
               cnt_d   = '0;
               ovf_d   = 1'b0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (fall_cs) begin
               if (cnt_q == C_CNT_FULL && !ovf_q) begin
                  tracks_d      = shift_q;
                  frame_valid_d = 1'b1;
                  frame_cnt_d   = frame_cnt_q + 8'd1;
                  track_upd_d   = word_diff;
               end else begin
                  frame_err_d = 1'b1;
               end
               state_d = IDLE;
            end else if (rise_sck && cs_s) begin
               shift_d = {shift_q[W-2:0], sdi_s};
               if (cnt_q == C_CNT_FULL) begin
                  ovf_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = ARM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= ARM;
         cs_sync_q     <= '0;
         sck_sync_q    <= '0;
         sdi_sync_q    <= '0;
         cs_dly_q      <= 1'b0;
         sck_dly_q     <= 1'b0;
         shift_q       <= '0;
         cnt_q         <= '0;
         ovf_q         <= 1'b0;
         arm_cnt_q     <= '0;
         tracks_q      <= '0;
         frame_valid_q <= 1'b0;
         frame_err_q   <= 1'b0;
         track_upd_q   <= '0;
         frame_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         cs_sync_q     <= cs_sync_d;
         sck_sync_q    <= sck_sync_d;
         sdi_sync_q    <= sdi_sync_d;
         cs_dly_q      <= cs_s;
         sck_dly_q     <= sck_s;
         shift_q       <= shift_d;
         cnt_q         <= cnt_d;
         ovf_q         <= ovf_d;
         arm_cnt_q     <= arm_cnt_d;
         tracks_q      <= tracks_d;
         frame_valid_q <= frame_valid_d;
         frame_err_q   <= frame_err_d;
         track_upd_q   <= track_upd_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end

   assign tracks_out  = tracks_q;
   assign frame_valid = frame_valid_q;
   assign frame_err   = frame_err_q;
   assign track_upd   = track_upd_q;
   assign frame_cnt   = frame_cnt_q;
   assign busy        = (state_q == SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_spi_track_frame_rx.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_spi_track_frame_rx : directed bench for 4x24 and 1x16 receiver builds  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_spi_track_frame_rx;

   localparam logic [95:0] F1 = 96'h0114ff0217ff0114ff0217ff;
   localparam logic [95:0] F2 = 96'h0114ff0217ff0114ff0300ff;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic cs_a = 1'b0, sck_a = 1'b0, sdi_a = 1'b0;
   logic cs_b = 1'b0, sck_b = 1'b0, sdi_b = 1'b0;

   logic [95:0] tracks_a;
   logic        fv_a, fe_a, busy_a;
   logic [3:0]  upd_a;
   logic [7:0]  cnt_a;

   logic [15:0] tracks_b;
   logic        fv_b, fe_b, busy_b;
   logic [0:0]  upd_b;
   logic [7:0]  cnt_b;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   spi_track_frame_rx #(.NUM_TRACKS(4), .PACKET_SIZE(24), .SYNC_STAGES(2)) u_dut_a (
      .clk(clk), .reset(reset), .cs(cs_a), .sck(sck_a), .sdi(sdi_a),
      .tracks_out(tracks_a), .frame_valid(fv_a), .frame_err(fe_a),
      .track_upd(upd_a), .frame_cnt(cnt_a), .busy(busy_a));

   spi_track_frame_rx #(.NUM_TRACKS(1), .PACKET_SIZE(16), .SYNC_STAGES(2)) u_dut_b (
      .clk(clk), .reset(reset), .cs(cs_b), .sck(sck_b), .sdi(sdi_b),
      .tracks_out(tracks_b), .frame_valid(fv_b), .frame_err(fe_b),
      .track_upd(upd_b), .frame_cnt(cnt_b), .busy(busy_b));

   task automatic set_cs(input int sel, input logic v);
      if (sel == 0) cs_a = v; else cs_b = v;
   endtask

   task automatic spi_bit(input int sel, input logic b);
      if (sel == 0) sdi_a = b; else sdi_b = b;
      repeat (3) @(posedge clk);
      if (sel == 0) sck_a = 1'b1; else sck_b = 1'b1;
      repeat (3) @(posedge clk);
      if (sel == 0) sck_a = 1'b0; else sck_b = 1'b0;
   endtask

   // Observe a fixed window after cs drops; counts pulse cycles per kind.
   task automatic watch(input int sel, input int cycles, output int nv, output int ne,
                        output logic [3:0] upd);
      nv = 0; ne = 0; upd = 4'b0;
      repeat (cycles) begin
         @(negedge clk);
         if (sel == 0) begin
            if (fv_a) begin nv++; upd = upd_a; end
            if (fe_a) ne++;
         end else begin
            if (fv_b) begin nv++; upd = {3'b000, upd_b}; end
            if (fe_b) ne++;
         end
      end
   endtask

   task automatic send_frame(input int sel, input logic [127:0] data, input int n,
                             output int nv, output int ne, output logic [3:0] upd,
                             output logic busy_mid);
      set_cs(sel, 1'b1);
      repeat (4) @(posedge clk);
      for (int i = n - 1; i >= 0; i--) spi_bit(sel, data[i]);
      repeat (3) @(posedge clk);
      @(negedge clk);
      busy_mid = (sel == 0) ? busy_a : busy_b;
      @(posedge clk);
      set_cs(sel, 1'b0);
      watch(sel, 12, nv, ne, upd);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (4) @(posedge clk);
      reset = 1'b1;
      repeat (10) @(posedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      total++;
      if (tracks_a !== 96'h0 || fv_a !== 1'b0 || fe_a !== 1'b0 || upd_a !== 4'h0 ||
          cnt_a !== 8'h0 || busy_a !== 1'b0)
         $display("FAIL reset_a: tracks=%h fv=%b fe=%b upd=%b cnt=%0d busy=%b, required all 0",
                  tracks_a, fv_a, fe_a, upd_a, cnt_a, busy_a);
      else passed++;
      total++;
      if (tracks_b !== 16'h0 || cnt_b !== 8'h0 || busy_b !== 1'b0)
         $display("FAIL reset_b: tracks=%h cnt=%0d busy=%b, required all 0", tracks_b, cnt_b, busy_b);
      else passed++;
   endtask

   task automatic test_first_frame();
      int nv, ne; logic [3:0] upd; logic bm;
      send_frame(0, {32'h0, F1}, 96, nv, ne, upd, bm);
      total++;
      if (bm !== 1'b1) $display("FAIL busy_mid: got %b required 1", bm); else passed++;
      total++;
      if (nv !== 1 || ne !== 0)
         $display("FAIL first_pulse: valid_cycles=%0d err_cycles=%0d required 1/0", nv, ne);
      else passed++;
      total++;
      if (tracks_a !== F1) $display("FAIL first_tracks: got %h required %h", tracks_a, F1);
      else passed++;
      total++;
      if (cnt_a !== 8'd1 || upd !== 4'b1111)
         $display("FAIL first_cnt_upd: cnt=%0d upd=%b required 1/1111", cnt_a, upd);
      else passed++;
      total++;
      if (busy_a !== 1'b0 || upd_a !== 4'b0)
         $display("FAIL first_idle: busy=%b upd=%b required 0/0000", busy_a, upd_a);
      else passed++;
   endtask

   task automatic test_track_change();
      int nv, ne; logic [3:0] upd; logic bm;
      send_frame(0, {32'h0, F2}, 96, nv, ne, upd, bm);
      total++;
      if (nv !== 1 || ne !== 0 || upd !== 4'b0001 || cnt_a !== 8'd2)
         $display("FAIL change: valid=%0d err=%0d upd=%b cnt=%0d required 1/0/0001/2",
                  nv, ne, upd, cnt_a);
      else passed++;
      total++;
      if (tracks_a !== F2) $display("FAIL change_tracks: got %h required %h", tracks_a, F2);
      else passed++;
   endtask

   task automatic test_bad_length();
      int nv, ne; logic [3:0] upd; logic bm;
      send_frame(0, {32'h0, F1}, 95, nv, ne, upd, bm);
      total++;
      if (nv !== 0 || ne !== 1 || tracks_a !== F2 || cnt_a !== 8'd2)
         $display("FAIL short95: valid=%0d err=%0d cnt=%0d tracks=%h required 0/1/2/%h",
                  nv, ne, cnt_a, tracks_a, F2);
      else passed++;
      send_frame(0, {31'h0, 1'b1, F1}, 97, nv, ne, upd, bm);
      total++;
      if (nv !== 0 || ne !== 1 || tracks_a !== F2 || cnt_a !== 8'd2)
         $display("FAIL long97: valid=%0d err=%0d cnt=%0d tracks=%h required 0/1/2/%h",
                  nv, ne, cnt_a, tracks_a, F2);
      else passed++;
   endtask

   task automatic test_arm();
      int nv, ne; logic [3:0] upd; logic bm;
      cs_a = 1'b1;
      do_reset();
      for (int i = 0; i < 96; i++) spi_bit(0, F1[95-i]);
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if (busy_a !== 1'b0) $display("FAIL arm_busy: got %b required 0", busy_a); else passed++;
      @(posedge clk);
      cs_a = 1'b0;
      watch(0, 12, nv, ne, upd);
      total++;
      if (nv !== 0 || ne !== 0 || cnt_a !== 8'd0 || tracks_a !== 96'h0)
         $display("FAIL arm_nopulse: valid=%0d err=%0d cnt=%0d tracks=%h required 0/0/0/0",
                  nv, ne, cnt_a, tracks_a);
      else passed++;
      send_frame(0, {32'h0, F1}, 96, nv, ne, upd, bm);
      total++;
      if (nv !== 1 || tracks_a !== F1 || cnt_a !== 8'd1 || upd !== 4'b1111)
         $display("FAIL arm_next: valid=%0d cnt=%0d upd=%b tracks=%h required 1/1/1111/%h",
                  nv, cnt_a, upd, tracks_a, F1);
      else passed++;
   endtask

   task automatic test_mid_reset();
      int nv, ne; logic [3:0] upd; logic bm;
      cs_a = 1'b1;
      repeat (4) @(posedge clk);
      for (int i = 0; i < 40; i++) spi_bit(0, F2[95-i]);
      reset = 1'b0;
      cs_a  = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if (tracks_a !== 96'h0 || fv_a !== 1'b0 || fe_a !== 1'b0 || cnt_a !== 8'd0 ||
          busy_a !== 1'b0 || upd_a !== 4'h0)
         $display("FAIL midreset: tracks=%h fv=%b fe=%b cnt=%0d busy=%b required all 0",
                  tracks_a, fv_a, fe_a, cnt_a, busy_a);
      else passed++;
      reset = 1'b1;
      watch(0, 12, nv, ne, upd);
      total++;
      if (nv !== 0 || ne !== 0) $display("FAIL midreset_pulse: valid=%0d err=%0d required 0/0", nv, ne);
      else passed++;
      send_frame(0, {32'h0, F2}, 96, nv, ne, upd, bm);
      total++;
      if (nv !== 1 || tracks_a !== F2 || cnt_a !== 8'd1 || upd !== 4'b1111)
         $display("FAIL midreset_next: valid=%0d cnt=%0d upd=%b tracks=%h required 1/1/1111/%h",
                  nv, cnt_a, upd, tracks_a, F2);
      else passed++;
   endtask

   task automatic test_small_wrap();
      int nv, ne, nv_total; logic [3:0] upd; logic bm;
      logic [15:0] w;
      nv_total = 0;
      for (int k = 0; k < 256; k++) begin
         w = (k % 2 == 0) ? 16'h1234 : 16'hABCD;
         send_frame(1, {112'h0, w}, 16, nv, ne, upd, bm);
         nv_total += nv;
         if (k == 0) begin
            total++;
            if (nv !== 1 || ne !== 0 || tracks_b !== 16'h1234 || cnt_b !== 8'd1 || upd !== 4'b0001)
               $display("FAIL small_first: valid=%0d err=%0d tracks=%h cnt=%0d upd=%b required 1/0/1234/1/0001",
                        nv, ne, tracks_b, cnt_b, upd);
            else passed++;
         end
         if (k == 254) begin
            total++;
            if (cnt_b !== 8'd255) $display("FAIL small_255: cnt=%0d required 255", cnt_b);
            else passed++;
         end
      end
      total++;
      if (cnt_b !== 8'd0 || tracks_b !== 16'hABCD || nv_total !== 256)
         $display("FAIL small_wrap: cnt=%0d tracks=%h valid_pulses=%0d required 0/abcd/256",
                  cnt_b, tracks_b, nv_total);
      else passed++;
   endtask

   initial begin
      do_reset();
      test_reset();
      test_first_frame();
      test_track_change();
      test_bad_length();
      test_arm();
      test_mid_reset();
      test_small_wrap();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
